// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared types for the pipelined immediate generator.
//   immsrc_t : immediate format selector encodings (I/S/B/J/U/Z)
//   IMM_RSV6 / IMM_RSV7 : reserved selector codes, flagged as illegal
//   state_t  : occupancy of the output stage + skid buffer
// ---------------------------------------------------------------------------
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } immsrc_t;

  localparam logic [2:0] IMM_RSV6 = 3'b110;
  localparam logic [2:0] IMM_RSV7 = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // output stage invalid
    ST_ONE   = 2'd1,  // output stage valid, skid empty
    ST_TWO   = 2'd2   // output stage and skid both valid
  } state_t;

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Combinational immediate extractor / extender.
// Ports:
//   i_instr   [31:7]   instruction bits 31..7
//   i_immsrc  [2:0]    format selector (imm_pkg::immsrc_t encoding)
//   o_imm     [XLEN-1] extended immediate (0 for reserved selectors)
//   o_illegal          high when i_immsrc is a reserved code
// Parameter XLEN must be 32 or 64.
// ---------------------------------------------------------------------------
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  logic [2:0]      i_immsrc,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  // Every format is first built as a 32-bit value; the XLEN extension below
  // is then a uniform sign extension from bit 31. Z places zeros in bit 31,
  // so it comes out zero-extended without a special case.
  logic [31:0] w_imm32;
  logic        w_sign;

  assign w_sign = i_instr[31];

  always_comb begin
    w_imm32   = '0;
    o_illegal = 1'b0;
    case (i_immsrc)
      IMM_I: w_imm32 = {{20{w_sign}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_imm32 = {{19{w_sign}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J: w_imm32 = {{11{w_sign}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
      IMM_Z: w_imm32 = {27'b0, i_instr[19:15]};
      IMM_RSV6, IMM_RSV7: o_illegal = 1'b1;
    endcase
  end

  generate
    if (XLEN == 64) begin : g_rv64
      assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else if (XLEN == 32) begin : g_rv32
      assign o_imm = w_imm32;
    end else begin : g_bad_xlen
      $error("imm_decode: XLEN must be 32 or 64");
      assign o_imm = '0;
    end
  endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator with valid/ready on both sides, a registered
// output stage and a one-entry skid buffer. Decode happens once, at the
// input; the skid stores already-decoded results.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid / in_ready          upstream handshake (in_ready is registered)
//   in_instr [31:7]              instruction bits 31..7
//   in_immsrc [2:0]              format selector
//   in_tag [TAG_W-1:0]           sideband carried with the immediate
//   out_valid / out_ready        downstream handshake
//   out_imm [XLEN-1:0]           extended immediate
//   out_tag [TAG_W-1:0]          tag matching out_imm
//   out_illegal                  selector was a reserved code
// ---------------------------------------------------------------------------
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  state_t            r_state;
  state_t            w_state_next;

  logic [XLEN-1:0]   w_dec_imm;
  logic              w_dec_illegal;

  logic [XLEN-1:0]   r_out_imm;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_out_illegal;
  logic [XLEN-1:0]   r_skid_imm;
  logic [TAG_W-1:0]  r_skid_tag;
  logic              r_skid_illegal;

  logic              w_accept;
  logic              w_load_out_in;    // output stage <- freshly decoded beat
  logic              w_load_out_skid;  // output stage <- skid contents
  logic              w_load_skid;      // skid <- freshly decoded beat

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_instr   (in_instr),
    .i_immsrc  (in_immsrc),
    .o_imm     (w_dec_imm),
    .o_illegal (w_dec_illegal)
  );

  // Skid occupancy is exactly ST_TWO, so in_ready depends only on the state
  // register and never on out_ready.
  assign in_ready    = (r_state != ST_TWO);
  assign out_valid   = (r_state != ST_EMPTY);
  assign w_accept    = in_valid && in_ready;

  assign out_imm     = r_out_imm;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_illegal;

  always_comb begin
    w_state_next    = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_next  = ST_ONE;
          w_load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && out_ready) begin
          // Drain and refill on the same edge keeps 1 beat/cycle.
          w_load_out_in = 1'b1;
        end else if (w_accept) begin
          w_state_next = ST_TWO;
          w_load_skid  = 1'b1;
        end else if (out_ready) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          w_state_next    = ST_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_imm      <= '0;
      r_out_tag      <= '0;
      r_out_illegal  <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_tag     <= '0;
      r_skid_illegal <= 1'b0;
    end else begin
      if (w_load_out_in) begin
        r_out_imm     <= w_dec_imm;
        r_out_tag     <= in_tag;
        r_out_illegal <= w_dec_illegal;
      end else if (w_load_out_skid) begin
        r_out_imm     <= r_skid_imm;
        r_out_tag     <= r_skid_tag;
        r_out_illegal <= r_skid_illegal;
      end
      if (w_load_skid) begin
        r_skid_imm     <= w_dec_imm;
        r_skid_tag     <= in_tag;
        r_skid_illegal <= w_dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives an XLEN=32 and an XLEN=64 instance from the same stimulus. Each
// accepted beat pushes its hand-computed expectation into a per-instance
// queue; a monitor per instance pops and compares on every output transfer
// and also checks that a stalled output holds steady.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int TAG_W = 5;
  localparam int NVEC  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             in_valid;
  logic [31:7]      in_instr;
  logic [2:0]       in_immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready32, out_valid32, out_illegal32;
  logic [31:0]      out_imm32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, out_illegal64;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready32),
    .in_instr    (in_instr),
    .in_immsrc   (in_immsrc),
    .in_tag      (in_tag),
    .out_valid   (out_valid32),
    .out_ready   (out_ready),
    .out_imm     (out_imm32),
    .out_tag     (out_tag32),
    .out_illegal (out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready64),
    .in_instr    (in_instr),
    .in_immsrc   (in_immsrc),
    .in_tag      (in_tag),
    .out_valid   (out_valid64),
    .out_ready   (out_ready),
    .out_imm     (out_imm64),
    .out_tag     (out_tag64),
    .out_illegal (out_illegal64)
  );

  typedef struct packed {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  // Hand-computed expectations (e32 zero-extended to 64 bits).
  localparam vec_t VECS [NVEC] = '{
    '{32'hFFF00093, 3'b000, 64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0},
    '{32'h12300093, 3'b000, 64'h0000000000000123, 64'h0000000000000123, 1'b0},
    '{32'hFE112C23, 3'b001, 64'h00000000FFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0},
    '{32'hFE000EE3, 3'b010, 64'h00000000FFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0},
    '{32'h0080006F, 3'b011, 64'h0000000000000008, 64'h0000000000000008, 1'b0},
    '{32'h800000B7, 3'b100, 64'h0000000080000000, 64'hFFFFFFFF80000000, 1'b0},
    '{32'h123450B7, 3'b100, 64'h0000000012345000, 64'h0000000012345000, 1'b0},
    '{32'h000F8073, 3'b101, 64'h000000000000001F, 64'h000000000000001F, 1'b0},
    '{32'hFFFFFFFF, 3'b101, 64'h000000000000001F, 64'h000000000000001F, 1'b0},
    '{32'hFFFFFFFF, 3'b110, 64'h0000000000000000, 64'h0000000000000000, 1'b1},
    '{32'hFFFFFFFF, 3'b111, 64'h0000000000000000, 64'h0000000000000000, 1'b1}
  };

  exp_t q32[$];
  exp_t q64[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat, waits for both instances to be ready, records the
  // expectation just before the accepting edge. Returns at posedge+1.
  task automatic send(input logic [31:0] instr, input logic [2:0] src,
                      input logic [TAG_W-1:0] tag, input logic [63:0] e32,
                      input logic [63:0] e64, input logic ill);
    exp_t a;
    exp_t b;
    int   cnt;
    in_valid  = 1'b1;
    in_instr  = instr[31:7];
    in_immsrc = src;
    in_tag    = tag;
    cnt       = 0;
    @(negedge clk);
    while (!(in_ready32 && in_ready64) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: tag %0d never accepted, in_ready32=%0b in_ready64=%0b, required 1",
               tag, in_ready32, in_ready64);
      in_valid = 1'b0;
    end else begin
      a.imm = e32; a.tag = tag; a.ill = ill;
      b.imm = e64; b.tag = tag; b.ill = ill;
      q32.push_back(a);
      q64.push_back(b);
    end
    sync();
    in_valid = 1'b0;
  endtask

  // Monitor for the XLEN=32 instance.
  initial begin
    logic held;
    exp_t hv;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 1'b0;
      end else begin
        if (held && out_valid32) begin
          chk("hold32_imm", {32'b0, out_imm32}, hv.imm);
          chk("hold32_tag", out_tag32, hv.tag);
          chk("hold32_ill", out_illegal32, hv.ill);
        end
        if (out_valid32 && out_ready) begin
          held = 1'b0;
          if (q32.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out32_unexpected: got tag %0d, required no output", out_tag32);
          end else begin
            e = q32.pop_front();
            chk("out32_imm", {32'b0, out_imm32}, e.imm);
            chk("out32_tag", out_tag32, e.tag);
            chk("out32_ill", out_illegal32, e.ill);
            $display("xlen32 tag %0d imm 0x%08h illegal %0b", out_tag32, out_imm32, out_illegal32);
          end
        end else if (out_valid32) begin
          held   = 1'b1;
          hv.imm = {32'b0, out_imm32};
          hv.tag = out_tag32;
          hv.ill = out_illegal32;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // Monitor for the XLEN=64 instance.
  initial begin
    logic held;
    exp_t hv;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 1'b0;
      end else begin
        if (held && out_valid64) begin
          chk("hold64_imm", out_imm64, hv.imm);
          chk("hold64_tag", out_tag64, hv.tag);
          chk("hold64_ill", out_illegal64, hv.ill);
        end
        if (out_valid64 && out_ready) begin
          held = 1'b0;
          if (q64.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out64_unexpected: got tag %0d, required no output", out_tag64);
          end else begin
            e = q64.pop_front();
            chk("out64_imm", out_imm64, e.imm);
            chk("out64_tag", out_tag64, e.tag);
            chk("out64_ill", out_illegal64, e.ill);
            $display("xlen64 tag %0d imm 0x%016h illegal %0b", out_tag64, out_imm64, out_illegal64);
          end
        end else if (out_valid64) begin
          held   = 1'b1;
          hv.imm = out_imm64;
          hv.tag = out_tag64;
          hv.ill = out_illegal64;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_immsrc = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid32", out_valid32, 0);
    chk("rst_out_imm32", out_imm32, 0);
    chk("rst_out_tag32", out_tag32, 0);
    chk("rst_out_ill32", out_illegal32, 0);
    chk("rst_in_ready32", in_ready32, 1);
    chk("rst_out_valid64", out_valid64, 0);
    chk("rst_out_imm64", out_imm64, 0);
    chk("rst_in_ready64", in_ready64, 1);

    // First beat: one-cycle latency with out_ready high.
    sync();
    out_ready = 1'b1;
    send(VECS[0].instr, VECS[0].src, 5'd10, VECS[0].e32, VECS[0].e64, VECS[0].ill);
    @(negedge clk);
    chk("latency32", out_valid32, 1);
    chk("latency64", out_valid64, 1);
    sync();

    // Remaining format vectors back-to-back at full throughput.
    for (int i = 1; i < NVEC; i++) begin
      send(VECS[i].instr, VECS[i].src, TAG_W'(10 + i), VECS[i].e32, VECS[i].e64, VECS[i].ill);
    end
    repeat (3) sync();

    // Backpressure: tags 1 and 2 fill output + skid, tag 3 is held upstream.
    out_ready = 1'b0;
    send(32'h00100093, 3'b000, 5'd1, 64'h1, 64'h1, 1'b0);
    send(32'h00200093, 3'b000, 5'd2, 64'h2, 64'h2, 1'b0);
    in_valid  = 1'b1;
    in_instr  = 25'(32'h00300093 >> 7);
    in_immsrc = 3'b000;
    in_tag    = 5'd3;
    @(negedge clk);
    chk("bp_in_ready32", in_ready32, 0);
    chk("bp_in_ready64", in_ready64, 0);
    repeat (2) @(negedge clk);
    chk("bp_still_full32", in_ready32, 0);
    chk("bp_out_tag32", out_tag32, 1);
    chk("bp_out_tag64", out_tag64, 1);
    sync();
    out_ready = 1'b1;
    send(32'h00300093, 3'b000, 5'd3, 64'h3, 64'h3, 1'b0);
    repeat (3) sync();
    chk("bp_q32_drained", q32.size(), 0);
    chk("bp_q64_drained", q64.size(), 0);

    // Reset while in TWO: stale tags 5 and 6 must never appear.
    out_ready = 1'b0;
    send(32'h00500093, 3'b000, 5'd5, 64'h5, 64'h5, 1'b0);
    send(32'h00600093, 3'b000, 5'd6, 64'h6, 64'h6, 1'b0);
    @(negedge clk);
    chk("two_in_ready32", in_ready32, 0);
    sync();
    reset_n = 1'b0;
    q32.delete();
    q64.delete();
    sync();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid32", out_valid32, 0);
    chk("rst2_in_ready32", in_ready32, 1);
    chk("rst2_out_valid64", out_valid64, 0);
    chk("rst2_in_ready64", in_ready64, 1);
    sync();
    out_ready = 1'b1;
    send(32'h00700093, 3'b000, 5'd7, 64'h7, 64'h7, 1'b0);
    @(negedge clk);
    chk("rst2_latency32", out_valid32, 1);
    chk("rst2_latency64", out_valid64, 1);
    repeat (4) sync();
    chk("end_q32_empty", q32.size(), 0);
    chk("end_q64_empty", q64.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It replaces the purely combinational extender and adds:
- XLEN-generic sign extension, for RV32 and RV64.
- A CSR zero-extended immediate (zimm) mode.
- An illegal-selector flag.
- A valid/ready interface with a registered output stage and a one-entry skid buffer, so decode can stall without dropping instructions.

It sits between the fetch/decode register and the execute operand mux.

Parameters:
XLEN, 32, datapath width of the extended immediate; legal values 32 or 64.
TAG_W, 5, width of the sideband tag carried alongside each immediate (e.g. rd or ROB index).

Ports:
clk  input  1  single clock, rising edge.
reset_n  input  1  synchronous, active-low reset.
in_valid  input  1  upstream has an instruction.
in_ready  output  1  block can accept this cycle.
in_instr  input  25  instruction bits [31:7].
in_immsrc  input  3  immediate format selector (encoding below).
in_tag  input  TAG_W  sideband, passed through unchanged.
out_valid  output  1  out_imm/out_tag/out_illegal valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  extended immediate.
out_tag  output  TAG_W  tag matching out_imm.
out_illegal  output  1  in_immsrc was a reserved encoding.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (reset_n), sampled on the rising edge of clk.
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, skid empty, in_ready=1 from the first edge after reset.
- Format encodings (sign bit s = instr[31], replicated to XLEN):
  - 000 I: s-ext {instr[31:20]}.
  - 001 S: s-ext {instr[31:25], instr[11:7]}.
  - 010 B: s-ext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: s-ext {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN (RV64 LUI/AUIPC semantics).
  - 101 Z: zero-extended instr[19:15] (CSR zimm).
  - 110/111: imm=0, illegal=1.
- Legal formats produce illegal=0.
- Latency: exactly 1 cycle from the accepting edge to out_valid, when the output stage is empty or draining.
- Handshake: transfer occurs when valid && ready on the same edge. Once out_valid=1, out_imm/out_tag/out_illegal stay stable until out_ready=1.
- in_ready = !skid_valid. It is driven from a register only (no combinational path from out_ready). in_ready is independent of in_valid.
- States:
  - EMPTY: output stage invalid.
  - ONE: output stage valid, skid empty.
  - TWO: output stage and skid both valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept & !out_ready -> TWO; the new beat goes to skid.
  - ONE + accept & out_ready -> ONE; the output is overwritten with the new beat.
  - ONE + !accept & out_ready -> EMPTY.
  - TWO + out_ready -> ONE; skid moves to output. in_ready=0 in TWO, so no accept is possible.
- Ordering: strictly FIFO. No beat is lost or duplicated.
- Simultaneous accept and drain in ONE: the result stays in ONE with the new data, giving full throughput of 1 beat/cycle.
- Reset mid-operation: reset_n=0 on any edge discards both output and skid contents. The block returns to EMPTY regardless of in_valid/out_ready.
- XLEN other than 32/64: elaboration-time error.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [2:0] immsrc_t {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z}.
  - Constants for the reserved codes.
  - A state enum {ST_EMPTY, ST_ONE, ST_TWO}.
- Sub-module imm_decode: combinational, parametrised by XLEN. Maps (instr, immsrc) to (imm, illegal).
- imm_gen_pipe instantiates imm_decode at its input and registers the result; there is no decode after the skid.

Test Plan:
- XLEN=32, out_ready=1: instr 0xFFF00093, immsrc=I -> one cycle later out_valid=1, out_imm=0xFFFFFFFF, illegal=0.
- B-type instr 0xFE000EE3 -> out_imm=0xFFFFFFFC. J-type instr 0x0080006F -> out_imm=0x00000008.
- XLEN=64: U-type instr 0x800000B7 -> out_imm=0xFFFFFFFF80000000. Z-type with instr[19:15]=11111 -> out_imm=0x1F.
- Backpressure:
  - Stimulus: out_ready=0; present tags 1, 2, 3 back-to-back.
  - Expect after tags 1 and 2 are accepted: in_ready=0 and tag 3 held upstream.
  - Then raise out_ready -> tags emerge 1, 2, 3 in order, one per cycle, with no duplicates.
- Reserved encodings: immsrc=110 and 111 with instr all-ones -> out_imm=0, out_illegal=1, tag passed through.
- Reset from the TWO state: drive reset_n=0 for one edge -> out_valid=0 and in_ready=1 after that edge. The next beat (tag 7) appears with 1-cycle latency, and the stale tags are never output.
